// File: rtl/seg_display_scheduler_pkg.sv
// Shared types and constants for the two-digit 7-segment refresh scheduler.
// Glyphs are {G,F,E,D,C,B,A}, active-high.
package seg_display_scheduler_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    OFF,
    SHOW_LSD,
    BLANK_L,
    SHOW_MSD,
    BLANK_M
  } state_e;

  localparam logic DIG_SEL_LSD = 1'b0;
  localparam logic DIG_SEL_MSD = 1'b1;

  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b1101111;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b1110111;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b1111100;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b0111001;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b1011110;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b1110001;

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Valid/ready digit-pair handshake between the application and the scheduler.
interface seg_display_scheduler_if;

  logic                                        value_valid;
  logic                                        value_ready;
  logic [seg_display_scheduler_pkg::DIGIT_W-1:0] msd;
  logic [seg_display_scheduler_pkg::DIGIT_W-1:0] lsd;

  modport master (output value_valid, output msd, output lsd, input value_ready);
  modport slave  (input value_valid, input msd, input lsd, output value_ready);

endinterface

// File: rtl/seg_display_scheduler_glyph_rom.sv
// Combinational hex digit to 7-segment glyph decode.
module seg_glyph_rom
  import seg_display_scheduler_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = '0;
    case (digit)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      default: seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Two-digit 7-segment refresh scheduler with double-buffered digits and
// blanking dead-time around each digit swap.
module seg_display_scheduler
  import seg_display_scheduler_pkg::*;
#(
  parameter int REFRESH_DIV  = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  lzb_en_i,
  seg_display_scheduler_if.slave value_if,
  output logic [SEG_W-1:0]      seg_o,
  output logic                  dig_sel_o,
  output logic                  frame_o
);

  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC + 1);
  localparam logic [TIMER_W-1:0] SHOW_LOAD  = TIMER_W'(REFRESH_DIV - 1);
  localparam logic [TIMER_W-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? TIMER_W'(BLANK_CYCLES - 1) : '0;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [DIGIT_W-1:0]   act_msd_q, act_lsd_q, act_msd_d, act_lsd_d;
  logic [DIGIT_W-1:0]   pend_msd_q, pend_lsd_q;
  logic                 pend_full_q;
  logic                 frame_edge, drain, take;
  logic [DIGIT_W-1:0]   rom_digit;
  logic [SEG_W-1:0]     rom_seg, seg_d;
  logic                 dig_sel_d;

  // The timer counts down the remaining cycles of the current phase.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:      state_d = SHOW_LSD;
        SHOW_LSD: if (timer_q == '0) state_d = HAS_BLANK ? BLANK_L : SHOW_MSD;
        BLANK_L:  if (timer_q == '0) state_d = SHOW_MSD;
        SHOW_MSD: if (timer_q == '0) state_d = HAS_BLANK ? BLANK_M : SHOW_LSD;
        BLANK_M:  if (timer_q == '0) state_d = SHOW_LSD;
        default:  state_d = OFF;
      endcase
    end

    timer_d = timer_q;
    if (state_d != state_q) begin
      case (state_d)
        SHOW_LSD, SHOW_MSD: timer_d = SHOW_LOAD;
        BLANK_L, BLANK_M:   timer_d = BLANK_LOAD;
        default:            timer_d = '0;
      endcase
    end else if (timer_q != '0) begin
      timer_d = timer_q - TIMER_W'(1);
    end
  end

  assign frame_edge           = (state_d == SHOW_LSD) && (state_q != SHOW_LSD);
  assign drain                = pend_full_q && (frame_edge || (state_q == OFF));
  assign take                 = value_if.value_valid && !pend_full_q;
  assign value_if.value_ready = !pend_full_q;

  assign act_msd_d = drain ? pend_msd_q : act_msd_q;
  assign act_lsd_d = drain ? pend_lsd_q : act_lsd_q;

  // Outputs are decoded from next-state values so they register with the state.
  assign rom_digit = (state_d == SHOW_MSD) ? act_msd_d : act_lsd_d;

  seg_glyph_rom u_glyph_rom (
    .digit (rom_digit),
    .seg   (rom_seg)
  );

  always_comb begin
    seg_d     = '0;
    dig_sel_d = DIG_SEL_LSD;
    case (state_d)
      SHOW_LSD: seg_d = rom_seg;
      SHOW_MSD: begin
        seg_d     = (lzb_en_i && (act_msd_d == '0)) ? '0 : rom_seg;
        dig_sel_d = DIG_SEL_MSD;
      end
      BLANK_M:  dig_sel_d = DIG_SEL_MSD;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= OFF;
      timer_q     <= '0;
      act_msd_q   <= '0;
      act_lsd_q   <= '0;
      pend_msd_q  <= '0;
      pend_lsd_q  <= '0;
      pend_full_q <= 1'b0;
      seg_o       <= '0;
      dig_sel_o   <= DIG_SEL_LSD;
      frame_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      act_msd_q <= act_msd_d;
      act_lsd_q <= act_lsd_d;
      if (take) begin
        pend_msd_q  <= value_if.msd;
        pend_lsd_q  <= value_if.lsd;
        pend_full_q <= 1'b1;
      end else if (drain) begin
        pend_full_q <= 1'b0;
      end
      seg_o     <= seg_d;
      dig_sel_o <= dig_sel_d;
      frame_o   <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench: dut_a runs REFRESH_DIV=4/BLANK_CYCLES=1, dut_b runs 1/0.
`timescale 1ns/1ps
module tb_seg_display_scheduler;
  import seg_display_scheduler_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_a, en_b, lzb_a, lzb_b;
  logic [6:0] seg_a, seg_b;
  logic dig_a, dig_b, frame_a, frame_b;

  seg_display_scheduler_if if_a();
  seg_display_scheduler_if if_b();

  seg_display_scheduler #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a), .lzb_en_i(lzb_a),
    .value_if(if_a.slave), .seg_o(seg_a), .dig_sel_o(dig_a), .frame_o(frame_a)
  );

  seg_display_scheduler #(.REFRESH_DIV(1), .BLANK_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .lzb_en_i(lzb_b),
    .value_if(if_b.slave), .seg_o(seg_b), .dig_sel_o(dig_b), .frame_o(frame_b)
  );

  typedef struct {
    logic [3:0] msd;
    logic [3:0] lsd;
    logic       lzb;
    logic [6:0] lsd_seg;
    logic [6:0] msd_seg;
  } vec_t;

  vec_t vecs[10];
  int n_compared   = 0;
  int n_mismatched = 0;

  function automatic logic [15:0] pack(input logic [6:0] s, input logic d, input logic f);
    return {7'b0, s, d, f};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: timed out waiting for DUT event", name);
  endtask

  // Offer a pair on the chosen port, hold until accepted, then drop valid.
  task automatic applyStimulus(input bit use_b, input logic [3:0] msd, input logic [3:0] lsd);
    int n = 0;
    if (use_b) begin if_b.value_valid = 1'b1; if_b.msd = msd; if_b.lsd = lsd; end
    else       begin if_a.value_valid = 1'b1; if_a.msd = msd; if_a.lsd = lsd; end
    while (!(use_b ? if_b.value_ready : if_a.value_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) reportTimeout("push_ready");
    @(negedge clk);
    if (use_b) if_b.value_valid = 1'b0;
    else       if_a.value_valid = 1'b0;
    checkOutput("ready_low_after_accept", {15'b0, use_b ? if_b.value_ready : if_a.value_ready}, 16'd0);
  endtask

  task automatic waitFrame(input bit use_b);
    int n = 0;
    @(negedge clk);
    while (!(use_b ? frame_b : frame_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) reportTimeout("wait_frame");
  endtask

  // Called at the frame_o cycle; walks one full frame plus the next frame start.
  task automatic checkFrameA(input int idx, input logic [6:0] lsd_seg, input logic [6:0] msd_seg);
    logic [15:0] exp;
    checkOutput($sformatf("v%0d_ready_after_drain", idx), {15'b0, if_a.value_ready}, 16'd1);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4)       exp = pack(lsd_seg, 1'b0, k == 0);
      else if (k == 4) exp = pack(7'b0, 1'b0, 1'b0);
      else if (k < 9)  exp = pack(msd_seg, 1'b1, 1'b0);
      else if (k == 9) exp = pack(7'b0, 1'b1, 1'b0);
      else             exp = pack(lsd_seg, 1'b0, 1'b1);
      checkOutput($sformatf("v%0d_k%0d", idx, k), pack(seg_a, dig_a, frame_a), exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ready_hi;
    vecs[0] = '{4'h4, 4'h2, 1'b0, 7'b1011011, 7'b1100110};
    vecs[1] = '{4'h0, 4'h7, 1'b1, 7'b0000111, 7'b0000000};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 7'b0111111, 7'b0000000};
    vecs[3] = '{4'h0, 4'h7, 1'b0, 7'b0000111, 7'b0111111};
    vecs[4] = '{4'hA, 4'hB, 1'b0, 7'b1111100, 7'b1110111};
    vecs[5] = '{4'hF, 4'hE, 1'b0, 7'b1111001, 7'b1110001};
    vecs[6] = '{4'h8, 4'h9, 1'b0, 7'b1101111, 7'b1111111};
    vecs[7] = '{4'hC, 4'hD, 1'b0, 7'b1011110, 7'b0111001};
    vecs[8] = '{4'h1, 4'h6, 1'b0, 7'b1111101, 7'b0000110};
    vecs[9] = '{4'h3, 4'h5, 1'b1, 7'b1101101, 7'b1001111};

    rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; lzb_a = 1'b0; lzb_b = 1'b0;
    if_a.value_valid = 1'b0; if_a.msd = 4'h0; if_a.lsd = 4'h0;
    if_b.value_valid = 1'b0; if_b.msd = 4'h0; if_b.lsd = 4'h0;
    #1;
    checkOutput("reset_outputs", pack(seg_a, dig_a, frame_a), pack(7'b0, 1'b0, 1'b0));
    checkOutput("reset_ready", {15'b0, if_a.value_ready}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    waitFrame(1'b0);
    checkFrameA(99, 7'b0111111, 7'b0111111);

    for (int i = 0; i < 10; i++) begin
      lzb_a = vecs[i].lzb;
      applyStimulus(1'b0, vecs[i].msd, vecs[i].lsd);
      waitFrame(1'b0);
      checkFrameA(i, vecs[i].lsd_seg, vecs[i].msd_seg);
    end
    lzb_a = 1'b0;

    // Second offer must stall while the first one sits in the pending buffer.
    @(negedge clk);
    applyStimulus(1'b0, 4'h3, 4'h3);
    if_a.value_valid = 1'b1; if_a.msd = 4'h5; if_a.lsd = 4'h6;
    checkOutput("stall_old_value", pack(seg_a, dig_a, frame_a), pack(7'b1101101, 1'b0, 1'b0));
    ready_hi = 0;
    for (int n = 0; n < 50 && !frame_a; n++) begin
      if (if_a.value_ready) ready_hi++;
      @(negedge clk);
    end
    checkOutput("stall_ready_low", 16'(ready_hi), 16'd0);
    checkOutput("stall_drain_frame", pack(seg_a, dig_a, frame_a), pack(7'b1001111, 1'b0, 1'b1));
    checkOutput("stall_ready_after_drain", {15'b0, if_a.value_ready}, 16'd1);
    @(negedge clk);
    if_a.value_valid = 1'b0;
    checkOutput("stall_second_accepted", {15'b0, if_a.value_ready}, 16'd0);
    waitFrame(1'b0);
    checkOutput("stall_second_lsd", pack(seg_a, dig_a, frame_a), pack(7'b1111101, 1'b0, 1'b1));
    repeat (5) @(negedge clk);
    checkOutput("stall_second_msd", pack(seg_a, dig_a, frame_a), pack(7'b1101101, 1'b1, 1'b0));

    // Disable mid SHOW_MSD, load while OFF, re-enable.
    en_a = 1'b0;
    @(negedge clk);
    checkOutput("disable_blank", pack(seg_a, dig_a, frame_a), pack(7'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 4'h9, 4'h1);
    @(negedge clk);
    checkOutput("off_drain_ready", {15'b0, if_a.value_ready}, 16'd1);
    checkOutput("off_still_blank", pack(seg_a, dig_a, frame_a), pack(7'b0, 1'b0, 1'b0));
    en_a = 1'b1;
    @(negedge clk);
    checkOutput("reenable_frame", pack(seg_a, dig_a, frame_a), pack(7'b0000110, 1'b0, 1'b1));
    repeat (5) @(negedge clk);
    checkOutput("reenable_msd", pack(seg_a, dig_a, frame_a), pack(7'b1101111, 1'b1, 1'b0));

    // Asynchronous reset between edges during SHOW_MSD.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", pack(seg_a, dig_a, frame_a), pack(7'b0, 1'b0, 1'b0));
    checkOutput("async_reset_ready", {15'b0, if_a.value_ready}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_frame", pack(seg_a, dig_a, frame_a), pack(7'b0111111, 1'b0, 1'b1));

    // No blanking, one-cycle phases.
    applyStimulus(1'b1, 4'h7, 4'h3);
    waitFrame(1'b1);
    checkOutput("b_ready_after_drain", {15'b0, if_b.value_ready}, 16'd1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k % 2 == 0)
        checkOutput($sformatf("b_k%0d", k), pack(seg_b, dig_b, frame_b), pack(7'b1001111, 1'b0, 1'b1));
      else
        checkOutput($sformatf("b_k%0d", k), pack(seg_b, dig_b, frame_b), pack(7'b0000111, 1'b1, 1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
